vidout_line_capture: RTL and testbench

Pixel capture stage directly downstream of the graphics block: samples the 16-bit `VIDOUT` word once per `CLK_1H` rising edge during active video, converts IRGB to 24-bit RGB, and writes it into a ping-pong pair of line buffers. A downstream scan converter or frame dumper reads one completed line while the next is being written. The block also tracks horizontal and vertical position and reports framing errors.

---
 rtl/vidout_line_capture.sv | 233 +++++++++++++++++++++++
 tb/tb_vidout_line_capture.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vidout_line_capture.sv
// vidout_line_capture: captures active-video VIDOUT words into a ping-pong pair of RGB888 line buffers.
// Optional macro VIDCAP_INTENSITY_EN: scale each channel by the I nibble instead of replicating nibbles.
module vidout_line_capture #(
    parameter int H_ACTIVE = 336,
    parameter int V_ACTIVE = 240,
    parameter int AW       = 9
) (
    input  logic          reset,
    input  logic          CLK_1H,
    input  logic [15:0]   VIDOUT,
    input  logic          HBLANK_b,
    input  logic          VBLANK_b,
    input  logic          err_clr,
    input  logic [AW-1:0] rd_addr,
    output logic [23:0]   rd_data,
    output logic          rd_bank,
    output logic          line_ready,
    output logic [7:0]    line_num,
    output logic          frame_done,
    output logic          err_overrun,
    output logic          err_short
);

    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);
    localparam logic [XW-1:0] X_MAX = XW'(H_ACTIVE);
    localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE);

    typedef enum logic [1:0] {
        WAIT_FRAME,
        WAIT_LINE,
        ACTIVE,
        LINE_END
    } state_t;

`ifdef VIDCAP_INTENSITY_EN
    function automatic logic [23:0] conv_pixel(input logic [15:0] w);
        logic [7:0] i8;
        logic [7:0] r8;
        logic [7:0] g8;
        logic [7:0] b8;
        i8 = {4'd0, w[15:12]};
        r8 = {4'd0, w[11:8]} * i8;
        g8 = {4'd0, w[7:4]}  * i8;
        b8 = {4'd0, w[3:0]}  * i8;
        return {r8, g8, b8};
    endfunction

    logic [23:0] pix_conv;
    assign pix_conv = conv_pixel(VIDOUT);
`else
    function automatic logic [23:0] conv_pixel(input logic [11:0] w);
        return {w[11:8], w[11:8], w[7:4], w[7:4], w[3:0], w[3:0]};
    endfunction

    // Intensity nibble has no effect in this build.
    logic [3:0]  unused_intensity;
    logic [23:0] pix_conv;
    assign unused_intensity = VIDOUT[15:12];
    assign pix_conv         = conv_pixel(VIDOUT[11:0]);
`endif

    state_t        state_q, state_d;
    logic          hb_q, hb_d;
    logic          vb_q, vb_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [7:0]    line_num_q, line_num_d;
    logic          line_ready_q, line_ready_d;
    logic          frame_done_q, frame_done_d;
    logic          err_ovr_q, err_ovr_d;
    logic          err_short_q, err_short_d;
    logic          vend_pend_q, vend_pend_d;
    logic [23:0]   rd_data_q, rd_data_d;

    logic          vld_p1_q, vld_p1_d;
    logic [AW-1:0] addr_p1_q, addr_p1_d;
    logic [23:0]   pix_p1_q, pix_p1_d;

    logic [23:0]   mem [2**(AW+1)];

    logic          hb_rise, hb_fall, vb_rise, vb_fall;
    logic          live_line;
    logic          capture;
    logic [XW-1:0] cap_x;
    logic          set_ovr, set_short;

    assign hb_rise   = HBLANK_b & ~hb_q;
    assign hb_fall   = ~HBLANK_b & hb_q;
    assign vb_rise   = VBLANK_b & ~vb_q;
    assign vb_fall   = ~VBLANK_b & vb_q;
    assign live_line = (y_q < Y_MAX);

    always_comb begin
        hb_d         = HBLANK_b;
        vb_d         = VBLANK_b;
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        line_num_d   = line_num_q;
        line_ready_d = 1'b0;
        frame_done_d = 1'b0;
        vend_pend_d  = 1'b0;
        capture      = 1'b0;
        cap_x        = x_q;
        set_ovr      = 1'b0;
        set_short    = 1'b0;

        unique case (state_q)
            WAIT_FRAME: begin
                if (vb_rise) begin
                    state_d = WAIT_LINE;
                    y_d     = '0;
                end
            end
            WAIT_LINE: begin
                if (vb_fall) begin
                    state_d      = WAIT_FRAME;
                    frame_done_d = 1'b1;
                end else if (hb_rise && VBLANK_b) begin
                    state_d = ACTIVE;
                    x_d     = '0;
                    cap_x   = '0;
                    capture = 1'b1;
                    if (!live_line) set_ovr = 1'b1;
                end
            end
            ACTIVE: begin
                // Bank swap and line_ready are registered on entry to LINE_END so that the
                // last pixel (written on this same edge) is already visible with the pulse.
                if (hb_fall) begin
                    state_d     = LINE_END;
                    vend_pend_d = vb_fall;
                    if (x_q < X_MAX) set_short = 1'b1;
                    if (live_line) begin
                        line_ready_d = 1'b1;
                        rd_bank_d    = wr_bank_q;
                        wr_bank_d    = ~wr_bank_q;
                        line_num_d   = 8'(y_q);
                        y_d          = y_q + 1'b1;
                    end
                end else if (vb_fall) begin
                    state_d      = WAIT_FRAME;
                    frame_done_d = 1'b1;
                end else begin
                    capture = 1'b1;
                end
            end
            LINE_END: begin
                if (vend_pend_q || vb_fall) begin
                    state_d      = WAIT_FRAME;
                    frame_done_d = 1'b1;
                end else begin
                    state_d = WAIT_LINE;
                end
            end
            default: state_d = WAIT_FRAME;
        endcase

        if (capture) begin
            if (cap_x >= X_MAX) set_ovr = 1'b1;
            else                x_d     = cap_x + 1'b1;
        end

        vld_p1_d  = capture && live_line && (cap_x < X_MAX);
        addr_p1_d = AW'(cap_x);
        pix_p1_d  = pix_conv;

        err_ovr_d   = set_ovr   | (err_ovr_q   & ~err_clr);
        err_short_d = set_short | (err_short_q & ~err_clr);

        rd_data_d = mem[{rd_bank_q, rd_addr}];
    end

    always_ff @(posedge CLK_1H or posedge reset) begin
        if (reset) begin
            state_q      <= WAIT_FRAME;
            hb_q         <= 1'b1;
            vb_q         <= 1'b1;
            x_q          <= '0;
            y_q          <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b1;
            line_num_q   <= '0;
            line_ready_q <= 1'b0;
            frame_done_q <= 1'b0;
            err_ovr_q    <= 1'b0;
            err_short_q  <= 1'b0;
            vend_pend_q  <= 1'b0;
            vld_p1_q     <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            hb_q         <= hb_d;
            vb_q         <= vb_d;
            x_q          <= x_d;
            y_q          <= y_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            line_num_q   <= line_num_d;
            line_ready_q <= line_ready_d;
            frame_done_q <= frame_done_d;
            err_ovr_q    <= err_ovr_d;
            err_short_q  <= err_short_d;
            vend_pend_q  <= vend_pend_d;
            vld_p1_q     <= vld_p1_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Stage p1: converted pixel and its address, written into the write bank on the next edge.
    always_ff @(posedge CLK_1H) begin
        addr_p1_q <= addr_p1_d;
        pix_p1_q  <= pix_p1_d;
    end

    always_ff @(posedge CLK_1H) begin
        if (vld_p1_q) mem[{wr_bank_q, addr_p1_q}] <= pix_p1_q;
    end

    assign rd_data     = rd_data_q;
    assign rd_bank     = rd_bank_q;
    assign line_ready  = line_ready_q;
    assign line_num    = line_num_q;
    assign frame_done  = frame_done_q;
    assign err_overrun = err_ovr_q;
    assign err_short   = err_short_q;

endmodule

// File: tb/tb_vidout_line_capture.sv
// Randomized bench for vidout_line_capture against a line/frame level reference model.
// Geometry is scaled down (64 x 16) to keep whole frames short.
module tb_vidout_line_capture;

    localparam int H  = 64;
    localparam int V  = 16;
    localparam int AW = 6;

`ifdef VIDCAP_INTENSITY_EN
    localparam logic [23:0] PX5 = 24'h4B0096;
`else
    localparam logic [23:0] PX5 = 24'h5500AA;
`endif

    logic          reset;
    logic          CLK_1H = 1'b0;
    logic [15:0]   VIDOUT;
    logic          HBLANK_b, VBLANK_b, err_clr;
    logic [AW-1:0] rd_addr;
    logic [23:0]   rd_data;
    logic          rd_bank, line_ready, frame_done, err_overrun, err_short;
    logic [7:0]    line_num;

    vidout_line_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .AW(AW)) dut (
        .reset(reset), .CLK_1H(CLK_1H), .VIDOUT(VIDOUT), .HBLANK_b(HBLANK_b),
        .VBLANK_b(VBLANK_b), .err_clr(err_clr), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_bank(rd_bank), .line_ready(line_ready), .line_num(line_num),
        .frame_done(frame_done), .err_overrun(err_overrun), .err_short(err_short)
    );

    always #5 CLK_1H = ~CLK_1H;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge CLK_1H) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int num;
        int bank;
    } lr_ev_t;

    lr_ev_t lr_q[$];
    int     fd_q[$];

    always @(posedge CLK_1H) begin
        lr_ev_t ev;
        #1;
        if (line_ready === 1'b1) begin
            ev.cyc  = cyc;
            ev.num  = int'(line_num);
            ev.bank = int'(rd_bank);
            lr_q.push_back(ev);
        end
        if (frame_done === 1'b1) fd_q.push_back(cyc);
    end

    // Reference model state
    logic [23:0] m_mem [2][H];
    bit          m_vld [2][H];
    bit          m_wr, m_rd;
    int          m_num, m_y;
    bit          exp_ovr, exp_short;

    function automatic logic [23:0] conv(input logic [15:0] w);
        int i, r, g, b;
        i = int'(w[15:12]);
`ifdef VIDCAP_INTENSITY_EN
        r = int'(w[11:8]) * i;
        g = int'(w[7:4]) * i;
        b = int'(w[3:0]) * i;
`else
        r = int'(w[11:8]) * 17;
        g = int'(w[7:4]) * 17;
        b = int'(w[3:0]) * 17;
`endif
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input bit h, input bit v, input logic [15:0] pix);
        @(negedge CLK_1H);
        HBLANK_b = h;
        VBLANK_b = v;
        VIDOUT   = pix;
    endtask

    task automatic rd_chk(input int a, input bit v);
        @(negedge CLK_1H);
        HBLANK_b = 1'b0;
        VBLANK_b = v;
        rd_addr  = AW'(a);
        @(posedge CLK_1H);
        #1;
        if (m_vld[m_rd][a]) chk("rd_data", rd_data, m_mem[m_rd][a]);
    endtask

    task automatic chk_outputs_reset();
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_bank", rd_bank, 1);
        chk("rst_line_ready", line_ready, 0);
        chk("rst_line_num", line_num, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err_overrun", err_overrun, 0);
        chk("rst_err_short", err_short, 0);
    endtask

    task automatic chk_events(input bit exp_lr, input int lr_e, input int lr_num, input int lr_bank,
                              input bit exp_fd, input int fd_e);
        lr_ev_t ev;
        int     fc;
        chk("line_ready_cnt", lr_q.size(), exp_lr);
        if (exp_lr && lr_q.size() > 0) begin
            ev = lr_q.pop_front();
            chk("line_ready_cyc", ev.cyc, lr_e);
            chk("line_ready_num", ev.num, lr_num);
            chk("line_ready_bank", ev.bank, lr_bank);
        end
        lr_q.delete();
        chk("frame_done_cnt", fd_q.size(), exp_fd);
        if (exp_fd && fd_q.size() > 0) begin
            fc = fd_q.pop_front();
            chk("frame_done_cyc", fc, fd_e);
        end
        fd_q.delete();
        chk("rd_bank", rd_bank, m_rd);
        chk("line_num", line_num, m_num);
        chk("err_overrun", err_overrun, exp_ovr);
        chk("err_short", err_short, exp_short);
    endtask

    task automatic pulse_clr();
        @(negedge CLK_1H);
        err_clr = 1'b1;
        @(negedge CLK_1H);
        err_clr   = 1'b0;
        exp_ovr   = 1'b0;
        exp_short = 1'b0;
        chk("err_overrun_clr", err_overrun, exp_ovr);
        chk("err_short_clr", err_short, exp_short);
    endtask

    // kind: 0 = HBLANK_b fall, 1 = VBLANK_b fall mid-line (abort), 2 = both fall together
    task automatic do_line(input int n, input int kind, input bit pat, input bit clr);
        logic [15:0] px;
        logic [23:0] cap [H];
        logic [3:0]  xi;
        int          e, nw, lr_num, lr_bank, fd_e;
        bit          live, exp_lr, exp_fd;
        live = (m_y < V);
        for (int i = 0; i < n; i++) begin
            xi = 4'(i);
            px = pat ? {4'hF, xi, 4'h0, 4'hA} : 16'($urandom);
            if (i < H) cap[i] = conv(px);
            step(1'b1, 1'b1, px);
        end
        case (kind)
            0:       step(1'b0, 1'b1, 16'($urandom));
            1:       step(1'b1, 1'b0, 16'($urandom));
            default: step(1'b0, 1'b0, 16'($urandom));
        endcase
        e  = cyc + 1;
        nw = (n < H) ? n : H;
        if (live) begin
            for (int i = 0; i < nw; i++) begin
                m_mem[m_wr][i] = cap[i];
                m_vld[m_wr][i] = 1'b1;
            end
        end
        if (n > H || !live) exp_ovr = 1'b1;
        exp_lr  = 1'b0;
        lr_num  = 0;
        lr_bank = 0;
        exp_fd  = (kind != 0);
        fd_e    = (kind == 2) ? e + 1 : e;
        if (kind != 1) begin
            if (n < H) exp_short = 1'b1;
            if (live) begin
                exp_lr  = 1'b1;
                lr_num  = m_y;
                lr_bank = int'(m_wr);
                m_num   = m_y;
                m_rd    = m_wr;
                m_wr    = ~m_wr;
                m_y++;
            end
        end
        repeat (3) step(1'b0, kind == 0, 16'h0);
        chk_events(exp_lr, e, lr_num, lr_bank, exp_fd, fd_e);
        if (clr) pulse_clr();
        rd_chk(5, kind == 0);
        for (int r = 0; r < 3; r++) rd_chk($urandom_range(0, H - 1), kind == 0);
    endtask

    // mode: 0 = fixed pattern, full lines; 1 = random with overrun line 0 and short line 1; 2 = random
    task automatic do_frame(input int nlines, input int mode, input int abort_line, input int abort_x,
                            input bit both_last);
        int n, r, e;
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h0);
        m_y = 0;
        step(1'b0, 1'b1, 16'h0);
        for (int y = 0; y < nlines; y++) begin
            n = H;
            if (mode != 0) begin
                r = $urandom_range(0, 7);
                if (r == 0)      n = H + $urandom_range(1, 5);
                else if (r == 1) n = H - $urandom_range(1, 20);
            end
            if (mode == 1 && y == 0) n = H + 4;
            if (mode == 1 && y == 1) n = H - 20;
            if (y == abort_line) begin
                do_line(abort_x, 1, mode == 0, 1'b0);
                return;
            end
            if (both_last && y == nlines - 1) begin
                do_line(n, 2, mode == 0, 1'b0);
                return;
            end
            do_line(n, 0, mode == 0, (y == 0) || ($urandom_range(0, 3) == 0));
        end
        step(1'b0, 1'b0, 16'h0);
        e = cyc + 1;
        repeat (3) step(1'b0, 1'b0, 16'h0);
        chk_events(1'b0, 0, 0, 0, 1'b1, e);
    endtask

    task automatic do_reset_mid();
        logic [15:0] px;
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h0);
        m_y = 0;
        step(1'b0, 1'b1, 16'h0);
        for (int y = 0; y < 3; y++) do_line(H, 0, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            px = 16'($urandom);
            step(1'b1, 1'b1, px);
            if (i < 49) begin
                m_mem[m_wr][i] = conv(px);
                m_vld[m_wr][i] = 1'b1;
            end
        end
        m_vld[m_wr][49] = 1'b0;
        @(negedge CLK_1H);
        reset = 1'b1;
        #1;
        chk_outputs_reset();
        m_wr      = 1'b0;
        m_rd      = 1'b1;
        m_num     = 0;
        exp_ovr   = 1'b0;
        exp_short = 1'b0;
        @(negedge CLK_1H);
        reset = 1'b0;
        repeat (10) step(1'b1, 1'b1, 16'($urandom));
        repeat (3)  step(1'b0, 1'b1, 16'h0);
        repeat (10) step(1'b1, 1'b1, 16'($urandom));
        repeat (3)  step(1'b0, 1'b1, 16'h0);
        repeat (4)  step(1'b0, 1'b0, 16'h0);
        chk_events(1'b0, 0, 0, 0, 1'b0, 0);
    endtask

    initial begin
        reset    = 1'b1;
        HBLANK_b = 1'b0;
        VBLANK_b = 1'b0;
        VIDOUT   = 16'h0;
        err_clr  = 1'b0;
        rd_addr  = '0;
        m_wr     = 1'b0;
        m_rd     = 1'b1;
        m_num    = 0;
        m_y      = 0;
        exp_ovr  = 1'b0;
        exp_short = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < H; a++) m_vld[b][a] = 1'b0;

        repeat (3) @(negedge CLK_1H);
        chk_outputs_reset();
        reset = 1'b0;

        do_frame(V, 0, -1, 0, 1'b0);
        @(negedge CLK_1H);
        rd_addr = AW'(5);
        @(posedge CLK_1H);
        #1;
        chk("pattern_px5", rd_data, PX5);

        do_frame(V, 1, -1, 0, 1'b1);
        do_frame(V, 2, 7, 40, 1'b0);
        do_frame(V + 2, 2, -1, 0, 1'b0);
        do_reset_mid();
        do_frame(V, 2, -1, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
